// File: rtl/timer_ctrl_if.sv
// Front-panel bundle between the board I/O and timer_ctrl: raw buttons/switch in,
// run/direction/clear/enable levels out toward the display block.
interface timer_ctrl_if;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_dir;
    logic       sw_ena;
    logic       time_zero;
    logic       st;
    logic       back;
    logic       clr;
    logic       ena;
    logic       alarm;
    logic [1:0] state;

    modport master (
        output btn_start, btn_clear, btn_dir, sw_ena, time_zero,
        input  st, back, clr, ena, alarm, state
    );

    modport slave (
        input  btn_start, btn_clear, btn_dir, sw_ena, time_zero,
        output st, back, clr, ena, alarm, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Stopwatch front-panel control: button sync/debounce, IDLE/RUN/PAUSE FSM, registered outputs.
// Optional countdown auto-stop with alarm is enabled by defining TIMER_AUTO_STOP_EN.
module timer_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // bit 0 = start, bit 1 = clear, bit 2 = dir
    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      stable_r;
    logic [2:0]      prev_r;
    logic [DB_W-1:0] cnt_r [3];
    logic [2:0]      pulse_s;
    logic            start_p_s;
    logic            clear_p_s;
    logic            dir_p_s;
    logic            sw1_r;
    logic            ena_r;
    logic            expired_s;

    logic [1:0]      state_r;
    logic            st_r;
    logic            back_r;
    logic            clr_r;
    logic            alarm_r;
    logic [1:0]      state_nx_s;
    logic            back_nx_s;
    logic            clr_nx_s;
    logic            alarm_nx_s;

    assign raw_s     = {bus.btn_dir, bus.btn_clear, bus.btn_start};
    assign pulse_s   = stable_r & ~prev_r;
    assign start_p_s = pulse_s[0];
    assign clear_p_s = pulse_s[1];
    assign dir_p_s   = pulse_s[2];

`ifdef TIMER_AUTO_STOP_EN
    assign expired_s = back_r & bus.time_zero;
`else
    logic unused_s;
    assign unused_s  = bus.time_zero;
    assign expired_s = 1'b0;
`endif

    // Synchronize buttons and switch, debounce buttons, remember last stable level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r  <= 3'b000;
            sync2_r  <= 3'b000;
            stable_r <= 3'b000;
            prev_r   <= 3'b000;
            sw1_r    <= 1'b0;
            ena_r    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            prev_r  <= stable_r;
            sw1_r   <= bus.sw_ena;
            ena_r   <= sw1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= {DB_W{1'b0}};
                end else if (cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= {DB_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Next-state logic; clear has priority over every other action
    always_comb begin
        state_nx_s = state_r;
        back_nx_s  = back_r;
        alarm_nx_s = alarm_r;
        clr_nx_s   = 1'b0;
        if (clear_p_s) begin
            state_nx_s = IDLE;
            clr_nx_s   = 1'b1;
            alarm_nx_s = 1'b0;
        end else begin
            case (state_r)
                IDLE, PAUSE: begin
                    if (start_p_s) begin
                        alarm_nx_s = 1'b0;
                        // an expired countdown cannot be restarted until time is reloaded
                        if (expired_s) begin
                            state_nx_s = state_r;
                        end else begin
                            state_nx_s = RUN;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                    if (dir_p_s) begin
                        back_nx_s = ~back_r;
                    end else begin
                        back_nx_s = back_r;
                    end
                end
                RUN: begin
                    if (expired_s) begin
                        state_nx_s = IDLE;
                        alarm_nx_s = 1'b1;
                    end else if (start_p_s) begin
                        state_nx_s = PAUSE;
                        alarm_nx_s = 1'b0;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // Register FSM state and all display-facing levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            st_r    <= 1'b0;
            back_r  <= 1'b0;
            clr_r   <= 1'b0;
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            st_r    <= (state_nx_s == RUN);
            back_r  <= back_nx_s;
            clr_r   <= clr_nx_s;
            alarm_r <= alarm_nx_s;
        end
    end

    assign bus.st    = st_r;
    assign bus.back  = back_r;
    assign bus.clr   = clr_r;
    assign bus.ena   = ena_r;
    assign bus.alarm = alarm_r;
    assign bus.state = state_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed plus random stimulus for timer_ctrl, checked every cycle against a
// window-based behavioural model of the debounced front panel.
module tb_timer_ctrl;

    localparam int DB = 4;
    localparam int HL = DB + 2;
    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_PAUSE = 2'b10;
`ifdef TIMER_AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    timer_ctrl_if bus();

    timer_ctrl #(.DB_CYCLES(DB), .DB_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state
    logic [1:0] m_state;
    bit m_back, m_clr, m_alarm, m_ena;
    bit m_stable [3];
    bit m_rise   [3];
    bit hist     [3][HL];
    bit sw_hist  [2];

    function automatic bit raw_of(input int b);
        case (b)
            0:       return bus.btn_start;
            1:       return bus.btn_clear;
            default: return bus.btn_dir;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_back  = 1'b0;
        m_clr   = 1'b0;
        m_alarm = 1'b0;
        m_ena   = 1'b0;
        sw_hist[0] = 1'b0;
        sw_hist[1] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_stable[b] = 1'b0;
            m_rise[b]   = 1'b0;
            for (int j = 0; j < HL; j++) hist[b][j] = 1'b0;
        end
    endtask

    // one active clock edge: act on pulses accepted at the previous edge,
    // then accept any level that has differed from the stable one for DB sampled cycles
    task automatic model_edge();
        bit s_p, c_p, d_p, expired, all_diff;
        s_p = m_rise[0];
        c_p = m_rise[1];
        d_p = m_rise[2];
        expired = AUTO && m_back && bus.time_zero;
        m_clr = 1'b0;
        if (c_p) begin
            m_state = M_IDLE;
            m_clr   = 1'b1;
            m_alarm = 1'b0;
        end else if (m_state == M_RUN) begin
            if (expired) begin
                m_state = M_IDLE;
                m_alarm = 1'b1;
            end else if (s_p) begin
                m_state = M_PAUSE;
                m_alarm = 1'b0;
            end
        end else begin
            if (s_p) begin
                m_alarm = 1'b0;
                if (!expired) m_state = M_RUN;
            end
            if (d_p) m_back = !m_back;
        end
        for (int b = 0; b < 3; b++) begin
            for (int j = HL - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw_of(b);
        end
        sw_hist[1] = sw_hist[0];
        sw_hist[0] = bus.sw_ena;
        m_ena = sw_hist[1];
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j < HL; j++) begin
                if (hist[b][j] == m_stable[b]) all_diff = 1'b0;
            end
            m_rise[b] = 1'b0;
            if (all_diff) begin
                m_stable[b] = !m_stable[b];
                m_rise[b]   = m_stable[b];
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all();
        check("st",    {1'b0, bus.st},    {1'b0, m_state == M_RUN});
        check("state", bus.state,         m_state);
        check("back",  {1'b0, bus.back},  {1'b0, m_back});
        check("clr",   {1'b0, bus.clr},   {1'b0, m_clr});
        check("ena",   {1'b0, bus.ena},   {1'b0, m_ena});
        check("alarm", {1'b0, bus.alarm}, {1'b0, m_alarm});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst) model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("rst_clr", {1'b0, bus.clr}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_dir   = 1'b0;
        bus.sw_ena    = 1'b0;
        bus.time_zero = 1'b0;
        do_reset();
        check("reset_state", bus.state, M_IDLE);

        // first press: st rises at edge DB+3
        bus.btn_start = 1'b1;
        tick(DB + 2);
        check("press_lat_st0", {1'b0, bus.st}, 2'b00);
        tick(1);
        check("press_lat_st1", {1'b0, bus.st}, 2'b01);
        check("press_state", bus.state, M_RUN);
        tick(3);
        bus.btn_start = 1'b0;
        tick(8);
        bus.btn_start = 1'b1;
        tick(7);
        check("pause_st", {1'b0, bus.st}, 2'b00);
        check("pause_state", bus.state, M_PAUSE);
        bus.btn_start = 1'b0;
        tick(8);

        // short bounces are discarded; switch raised to exercise ena
        bus.sw_ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.btn_start = 1'b1;
            tick(3);
            bus.btn_start = 1'b0;
            tick(2);
        end
        tick(8);
        check("bounce_state", bus.state, M_PAUSE);
        check("ena_follow", {1'b0, bus.ena}, 2'b01);

        // RUN, dir ignored; PAUSE, dir toggles
        bus.btn_start = 1'b1; tick(7); bus.btn_start = 1'b0; tick(8);
        bus.btn_dir = 1'b1; tick(7);
        check("dir_in_run", {1'b0, bus.back}, 2'b00);
        bus.btn_dir = 1'b0; tick(8);
        bus.btn_start = 1'b1; tick(7); bus.btn_start = 1'b0; tick(8);
        bus.btn_dir = 1'b1; tick(7);
        check("dir_in_pause", {1'b0, bus.back}, 2'b01);
        bus.btn_dir = 1'b0; tick(8);

        // clear wins over simultaneous start, back kept
        bus.btn_start = 1'b1; tick(7); bus.btn_start = 1'b0; tick(8);
        bus.btn_clear = 1'b1;
        bus.btn_start = 1'b1;
        tick(7);
        check("clr_state", bus.state, M_IDLE);
        check("clr_pulse", {1'b0, bus.clr}, 2'b01);
        check("clr_back", {1'b0, bus.back}, 2'b01);
        tick(1);
        check("clr_one_cycle", {1'b0, bus.clr}, 2'b00);
        bus.btn_clear = 1'b0;
        bus.btn_start = 1'b0;
        tick(8);

        // countdown reaching zero while running
        bus.btn_start = 1'b1; tick(7); bus.btn_start = 1'b0; tick(8);
        bus.time_zero = 1'b1;
        tick(1);
        check("tz_state", bus.state, AUTO ? M_IDLE : M_RUN);
        check("tz_alarm", {1'b0, bus.alarm}, {1'b0, AUTO});
        tick(3);
        bus.btn_start = 1'b1; tick(7);
        check("tz_start_alarm", {1'b0, bus.alarm}, 2'b00);
        check("tz_start_state", bus.state, AUTO ? M_IDLE : M_PAUSE);
        bus.btn_start = 1'b0; tick(8);
        bus.time_zero = 1'b0;

        // reset mid-debounce, button held through release counts as new press
        bus.btn_start = 1'b1;
        tick(2);
        do_reset();
        check("mid_rst_ena", {1'b0, bus.ena}, 2'b00);
        tick(7);
        check("held_thru_rst", bus.state, M_RUN);
        bus.btn_start = 1'b0;
        tick(8);

        // random phase
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) bus.btn_start = !bus.btn_start;
            if ($urandom_range(0, 11) == 0) bus.btn_clear = !bus.btn_clear;
            if ($urandom_range(0, 5) == 0) bus.btn_dir = !bus.btn_dir;
            if ($urandom_range(0, 9) == 0) bus.time_zero = !bus.time_zero;
            if ($urandom_range(0, 19) == 0) bus.sw_ena = !bus.sw_ena;
            if ($urandom_range(0, 399) == 0) do_reset();
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Front-panel control stage sitting directly upstream of the stopwatch/clock display block. It synchronizes and debounces three raw push-buttons and one enable switch, runs the IDLE/RUN/PAUSE state machine, and produces the run (`st`), count-direction (`back`), clear (`clr`) and display-enable (`ena`) levels that the display block consumes. All outputs are registered, so the display's asynchronous reset input never sees a glitch.

## Interface
- `DB_CYCLES`, default 1000000 — consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2 and ≤ 2^`DB_W`−1.
- `DB_W`, default 20 — width of each debounce counter.
- `clk` in 1 — system clock (100 MHz board clock).
- `rst` in 1 — asynchronous, active-high reset.
- `btn_start` in 1 — raw start/pause button, active-high, asynchronous.
- `btn_clear` in 1 — raw clear button, active-high, asynchronous.
- `btn_dir` in 1 — raw count-direction toggle button, active-high, asynchronous.
- `sw_ena` in 1 — raw display-enable switch, asynchronous.
- `time_zero` in 1 — high while displayed time is 00:00:00; driven by the display side.
- `st` out 1 — run level; 1 = count, 0 = hold.
- `back` out 1 — direction; 1 = count down, 0 = count up.
- `clr` out 1 — one-cycle clear pulse to the display block's reset.
- `ena` out 1 — display enable.
- `alarm` out 1 — countdown-expired flag (see Configuration).
- `state` out 2 — FSM state for debug: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.

## Operation
- Each button: 2-flop synchronizer → debouncer → rising-edge detector giving a one-cycle pulse (`start_p`, `clear_p`, `dir_p`).
- Debouncer: holds `stable`; while synchronized input ≠ `stable`, counter increments; when counter reaches `DB_CYCLES`−1 with input still different, `stable` takes the input and counter clears; whenever input = `stable`, counter clears. A bounce shorter than `DB_CYCLES` cycles is discarded.
- `sw_ena`: 2-flop synchronizer only; `ena` = synchronized value.
- FSM, priority order per cycle:
  - `clear_p` (any state) → IDLE, `clr`=1 for exactly that cycle; `back` retained; wins over simultaneous `start_p`/`dir_p`.
  - `start_p`: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - `dir_p`: toggles `back` in IDLE or PAUSE; ignored in RUN. Simultaneous `start_p` and `dir_p` in PAUSE: toggle applies, state → RUN.
- `st` = 1 exactly when state = RUN.
- Illegal state encoding 2'b11 → IDLE on next cycle.

## Timing
- Reset values: `st`=0, `back`=0, `clr`=0, `ena`=0, `alarm`=0, `state`=IDLE; all synchronizer flops, `stable` bits and counters 0.
- Press latency: input high and stable before rising edge 1 → `stable` flips at edge `DB_CYCLES`+2 → FSM/outputs update at edge `DB_CYCLES`+3.
- Release latency identical; releases generate no pulse.
- `ena` follows `sw_ena` 2 edges later.
- Button held through reset release: `stable`=0 after reset, so it counts as a new press `DB_CYCLES`+3 edges after release.
- Reset mid-debounce or mid-RUN: immediate return to reset values; no `clr` pulse emitted.
- Held button produces one pulse only; a second action needs release plus a re-press, each debounced.

## Configuration
- `TIMER_AUTO_STOP_EN` defined:
  - In RUN with `back`=1 and `time_zero`=1 → IDLE next edge, `alarm` set.
  - `alarm` stays high until the next `start_p` or `clear_p`, which clears it in addition to its normal action.
  - In IDLE/PAUSE with `back`=1 and `time_zero`=1, `start_p` is ignored (state unchanged) except clearing `alarm`.
- Not defined: `time_zero` ignored; `alarm` tied 0; countdown wraps per the display block.

## Test plan
- `DB_CYCLES`=4: `btn_start` raised before edge 1, held → `st` 0→1 at edge 7, `state`=01; release, press again → `st`=0, `state`=10.
- `btn_start` pulse 3 cycles wide, repeated with 2-cycle gaps → no state change, `st` stays 0.
- RUN, assert `btn_clear` and `btn_start` together → `state`=00, `st`=0, `clr` high exactly 1 cycle, `back` unchanged.
- `dir` press in RUN → `back` stays 0; pause, `dir` press → `back`=1; `rst` pulse mid-debounce → all outputs 0, no `clr`.
- With `TIMER_AUTO_STOP_EN`: `back`=1, RUN, raise `time_zero` → next edge `state`=00, `st`=0, `alarm`=1; `start_p` with `time_zero`=1 → `alarm`=0, `state` stays 00.
- Without macro: same stimulus → `state` stays 01, `alarm`=0.
